// File: rtl/egg_timer_ctrl.sv
// Egg timer countdown controller: BCD MM:SS set/run/pause/alarm sequencing.
// Optional macro ALARM_BLINK_EN blinks digit_en on each 1 Hz tick in ALARM.
module egg_timer_ctrl #(
  parameter int MAX_MIN     = 99,
  parameter int DEFAULT_MIN = 3,
  parameter int DEFAULT_SEC = 0,
  parameter int ALARM_SECS  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick_1Hz,
  input  logic       btn_start,
  input  logic       btn_min,
  input  logic       btn_sec,
  input  logic       btn_clear,
  output logic [3:0] sec_digit1,
  output logic [3:0] sec_digit2,
  output logic [3:0] min_digit1,
  output logic [3:0] min_digit2,
  output logic [3:0] digit_en,
  output logic       running,
  output logic       alarm
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE,
    S_ALARM
  } state_t;

  localparam logic [15:0] DEF_TM = {
    4'(DEFAULT_MIN / 10), 4'(DEFAULT_MIN % 10),
    4'(DEFAULT_SEC / 10), 4'(DEFAULT_SEC % 10)
  };

  state_t      state_q;
  logic [15:0] tm_q;
  logic [15:0] pre_q;
  logic [7:0]  acnt_q;
  logic        running_q;
  logic        alarm_q;

  logic [7:0]  min_d;
  logic [7:0]  sec_d;
  logic [15:0] dec_d;
  logic [6:0]  mbin;
  logic        any_btn;
  logic        last_tick;

  assign any_btn = btn_start | btn_min | btn_sec | btn_clear;
  assign last_tick = (ALARM_SECS != 0) && tick_1Hz &&
                     (acnt_q + 8'd1 == 8'(ALARM_SECS));

  // Increment and decrement candidates for the digit register.
  always_comb begin
    mbin = 7'(tm_q[15:12]) * 7'd10 + 7'(tm_q[11:8]);
    if (mbin >= 7'(MAX_MIN))
      min_d = 8'h00;
    else if (tm_q[11:8] == 4'd9)
      min_d = {tm_q[15:12] + 4'd1, 4'd0};
    else
      min_d = {tm_q[15:12], tm_q[11:8] + 4'd1};

    if (tm_q[7:0] == 8'h59)
      sec_d = 8'h00;
    else if (tm_q[3:0] == 4'd9)
      sec_d = {tm_q[7:4] + 4'd1, 4'd0};
    else
      sec_d = {tm_q[7:4], tm_q[3:0] + 4'd1};

    dec_d = tm_q;
    if (tm_q[3:0] != 4'd0) begin
      dec_d[3:0] = tm_q[3:0] - 4'd1;
    end else begin
      dec_d[3:0] = 4'd9;
      if (tm_q[7:4] != 4'd0) begin
        dec_d[7:4] = tm_q[7:4] - 4'd1;
      end else begin
        dec_d[7:4] = 4'd5;
        if (tm_q[11:8] != 4'd0) begin
          dec_d[11:8] = tm_q[11:8] - 4'd1;
        end else begin
          dec_d[11:8] = 4'd9;
          dec_d[15:12] = tm_q[15:12] - 4'd1;
        end
      end
    end
  end

`ifdef ALARM_BLINK_EN
  logic [3:0] en_q;
  assign digit_en = en_q;
`else
  assign digit_en = 4'b1111;
`endif

  // Main FSM with registered digits, preset and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      tm_q      <= DEF_TM;
      pre_q     <= DEF_TM;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
`ifdef ALARM_BLINK_EN
      en_q      <= 4'b1111;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (btn_clear) begin
            tm_q <= 16'h0000;
          end else if (btn_start) begin
            if (tm_q != 16'h0000) begin
              pre_q     <= tm_q;
              state_q   <= S_RUN;
              running_q <= 1'b1;
            end
          end else if (btn_min) begin
            tm_q[15:8] <= min_d;
          end else if (btn_sec) begin
            tm_q[7:0] <= sec_d;
          end
        end
        S_RUN: begin
          if (btn_clear) begin
            tm_q      <= 16'h0000;
            state_q   <= S_IDLE;
            running_q <= 1'b0;
          end else if (btn_start) begin
            state_q   <= S_PAUSE;
            running_q <= 1'b0;
          end else if (tick_1Hz) begin
            tm_q <= dec_d;
            if (dec_d == 16'h0000) begin
              state_q   <= S_ALARM;
              running_q <= 1'b0;
              alarm_q   <= 1'b1;
              acnt_q    <= 8'd0;
            end
          end
        end
        S_PAUSE: begin
          if (btn_clear) begin
            tm_q    <= 16'h0000;
            state_q <= S_IDLE;
          end else if (btn_start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_ALARM: begin
          if (any_btn || last_tick) begin
            tm_q    <= pre_q;
            state_q <= S_IDLE;
            alarm_q <= 1'b0;
            acnt_q  <= 8'd0;
`ifdef ALARM_BLINK_EN
            en_q    <= 4'b1111;
`endif
          end else if (tick_1Hz) begin
            if (ALARM_SECS != 0)
              acnt_q <= acnt_q + 8'd1;
`ifdef ALARM_BLINK_EN
            en_q <= ~en_q;
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign sec_digit1 = tm_q[3:0];
  assign sec_digit2 = tm_q[7:4];
  assign min_digit1 = tm_q[11:8];
  assign min_digit2 = tm_q[15:12];
  assign running    = running_q;
  assign alarm      = alarm_q;

endmodule
